alu_cmd_sequencer: RTL and testbench

Upstream command stage for the 8-bit combinational ALU. Accepts ALU commands (op, x, y) over a valid/ready handshake and buffers them in a small FIFO. Drives the FIFO head onto the ALU operand/op lines and registers the ALU's result and flags into an output slot with its own valid/ready handshake. An optional accumulator mode substitutes the last captured result for x, so operations can be chained.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_sequencer.sv | 97 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and command/result bundles for the ALU command path.
// Widths here must match the ALU datapath.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
    logic             acc;
  } cmd_t;

  typedef struct packed {
    logic [ALU_W-1:0] s;
    logic             c;
    logic             ovf;
    logic             zero;
    logic [2:0]       op;
  } res_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with combinational head read.
// DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives the FIFO head into the external ALU and
// registers its outputs into a handshaked result slot with accumulator.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_x,
  input  logic [W-1:0] cmd_y,
  input  logic         cmd_acc,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_s,
  input  logic         alu_c,
  input  logic         alu_ovf,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_s,
  output logic         res_c,
  output logic         res_ovf,
  output logic         res_zero,
  output logic [2:0]   res_op,
  output logic [W-1:0] acc
);

  localparam int CW = $clog2(DEPTH+1);

  cmd_t            wr_cmd;
  cmd_t            head;
  res_t            res_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            cap;

  assign wr_cmd = '{op: cmd_op, x: cmd_x, y: cmd_y, acc: cmd_acc};

  // Full is decoded from the registered count, so no push-through.
  assign cmd_ready = !fifo_full;
  assign cap = (fifo_count != '0) && (!res_valid || res_ready);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid && cmd_ready),
    .wr_data (wr_cmd),
    .pop     (cap),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_op = '0;
    if (!fifo_empty) begin
      alu_op = head.op;
      alu_y  = head.y;
      alu_x  = head.acc ? acc : head.x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      res_valid <= 1'b0;
      acc       <= '0;
    end else if (cap) begin
      res_q     <= '{s: alu_s, c: alu_c, ovf: alu_ovf,
                     zero: alu_zero, op: head.op};
      res_valid <= 1'b1;
      acc       <= alu_s;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_s    = res_q.s;
  assign res_c    = res_q.c;
  assign res_ovf  = res_q.ovf;
  assign res_zero = res_q.zero;
  assign res_op   = res_q.op;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU alongside.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_x;
  logic [W-1:0] cmd_y;
  logic         cmd_acc;
  logic [W-1:0] alu_x;
  logic [W-1:0] alu_y;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_s;
  logic         alu_c;
  logic         alu_ovf;
  logic         alu_zero;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_s;
  logic         res_c;
  logic         res_ovf;
  logic         res_zero;
  logic [2:0]   res_op;
  logic [W-1:0] acc;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_acc(cmd_acc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_s(alu_s), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_c(res_c), .res_ovf(res_ovf),
    .res_zero(res_zero), .res_op(res_op), .acc(acc)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic         zero;
  } alu_r_t;

  typedef struct {
    alu_r_t     r;
    logic [2:0] op;
  } exp_t;

  function automatic alu_r_t alu_f(input logic [2:0] op,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    alu_r_t   r;
    logic [W:0] wide;
    r = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, x} + {1'b0, y};
        r.s   = wide[W-1:0];
        r.c   = wide[W];
        r.ovf = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, x} + {1'b0, ~y} + 9'd1;
        r.s   = wide[W-1:0];
        r.c   = wide[W];
        r.ovf = (x[W-1] != y[W-1]) && (r.s[W-1] != x[W-1]);
      end
      OP_NOT: r.s = ~x;
      OP_AND: r.s = x & y;
      OP_OR:  r.s = x | y;
      OP_XOR: r.s = x ^ y;
      OP_SLT: r.s = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
      default: r.s = (x == y) ? 8'd1 : 8'd0;
    endcase
    r.zero = (r.s == '0);
    return r;
  endfunction

  always_comb begin
    {alu_s, alu_c, alu_ovf, alu_zero} = alu_f(alu_op, alu_x, alu_y);
  end

  int vectors     = 0;
  int miscompares = 0;
  exp_t q[$];
  logic [W-1:0] m_acc = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor/scoreboard: sample just before each active edge.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] xv;
    if (rst) begin
      q.delete();
      m_acc = '0;
    end else begin
      if (res_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_result: got res_s=%0h with no command pending",
                   res_s);
        end else begin
          e = q[0];
          check("res_s", 32'(res_s), 32'(e.r.s));
          check("res_c", 32'(res_c), 32'(e.r.c));
          check("res_ovf", 32'(res_ovf), 32'(e.r.ovf));
          check("res_zero", 32'(res_zero), 32'(e.r.zero));
          check("res_op", 32'(res_op), 32'(e.op));
          check("acc", 32'(acc), 32'(e.r.s));
          if (res_ready)
            void'(q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        xv     = cmd_acc ? m_acc : cmd_x;
        e.r    = alu_f(cmd_op, xv, cmd_y);
        e.op   = cmd_op;
        m_acc  = e.r.s;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic af);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_acc   = af;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got cmd_ready=0 for 50 cycles, need 1");
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic rand_cmd();
    cmd_op  = 3'($urandom_range(0, 7));
    cmd_x   = 8'($urandom);
    cmd_y   = 8'($urandom);
    cmd_acc = 1'($urandom);
  endtask

  initial begin
    int accepted;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_acc   = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_res_s", 32'(res_s), 32'd0);
    check("rst_res_op", 32'(res_op), 32'd0);
    check("rst_alu_x", 32'(alu_x), 32'd0);

    res_ready = 1'b1;
    send(OP_ADD, 8'd100, 8'd50, 1'b0);
    step();
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_s", 32'(res_s), 32'h96);
    check("t1_ovf", 32'(res_ovf), 32'd1);
    check("t1_c", 32'(res_c), 32'd0);
    check("t1_zero", 32'(res_zero), 32'd0);
    check("t1_acc", 32'(acc), 32'h96);

    send(OP_SUB, 8'd5, 8'd5, 1'b0);
    step();
    check("t2_sub_s", 32'(res_s), 32'd0);
    check("t2_sub_zero", 32'(res_zero), 32'd1);
    send(OP_EQ, 8'd7, 8'd7, 1'b0);
    step();
    check("t2_eq_s", 32'(res_s), 32'd1);
    step();
    step();

    // Stall the consumer and overfill.
    res_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      rand_cmd();
      if (cmd_ready)
        accepted++;
      step();
    end
    cmd_valid = 1'b0;
    check("t3_accepted", 32'(accepted), 32'd5);
    check("t3_full", 32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    step();
    check("t3_ready_back", 32'(cmd_ready), 32'd1);
    repeat (6) step();

    send(OP_ADD, 8'd3, 8'd4, 1'b0);
    send(OP_ADD, 8'($urandom), 8'd1, 1'b1);
    send(OP_XOR, 8'($urandom), 8'hFF, 1'b1);
    step();
    check("t4_s", 32'(res_s), 32'hF7);
    check("t4_acc", 32'(acc), 32'hF7);

    // Slot full plus DEPTH-1 queued, then steady push+capture.
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_cmd();
      send(cmd_op, cmd_x, cmd_y, cmd_acc);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_cmd();
      step();
      check("t5_ready", 32'(cmd_ready), 32'd1);
    end
    cmd_valid = 1'b0;
    repeat (DEPTH + 2) step();

    res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_cmd();
      send(cmd_op, cmd_x, cmd_y, cmd_acc);
    end
    check("t6_pre_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", 32'(res_valid), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_acc", 32'(acc), 32'd0);
    res_ready = 1'b1;
    repeat (5) begin
      step();
      check("t6_no_stale", 32'(res_valid), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom);
      rand_cmd();
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || res_valid) && n < 40) begin
      step();
      n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    check("drain_valid", 32'(res_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
